matrix_seq_ctrl: RTL and testbench

//  Parametrised multi-cycle sequencer for the matrix CPU. It fetches 27-bit instructions from instr_mem, decodes them,

---
 rtl/matrix_cpu_pkg.sv | 46 ++++
 rtl/matrix_instr_decode.sv | 37 +++
 rtl/matrix_seq_ctrl.sv | 160 ++++++++++++++++
 tb/tb_matrix_seq_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_cpu_pkg.sv
// Shared definitions for the matrix CPU sequencer: opcodes, instruction field
// positions, functional-unit indices, error codes and the sequencer state encoding.
package matrix_cpu_pkg;

  localparam int OP_W       = 5;
  localparam int OP_LSB     = 22;
  localparam int DEST_LSB   = 15;
  localparam int SRC1_LSB   = 8;
  localparam int SRC2_LSB   = 1;
  localparam int SCALAR_LSB = 0;

  localparam logic [OP_W-1:0] OP_NOP   = 5'h00;
  localparam logic [OP_W-1:0] OP_ADD   = 5'h01;
  localparam logic [OP_W-1:0] OP_SUB   = 5'h02;
  localparam logic [OP_W-1:0] OP_SCALE = 5'h03;
  localparam logic [OP_W-1:0] OP_MULT  = 5'h04;
  localparam logic [OP_W-1:0] OP_TRANS = 5'h05;
  localparam logic [OP_W-1:0] OP_HALT  = 5'h1F;

  localparam int UNIT_ADD_SUB = 0;
  localparam int UNIT_SCALE   = 1;
  localparam int UNIT_MULT    = 2;
  localparam int UNIT_TRANS   = 3;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_PC_OVF  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_READ,
    ST_EXEC,
    ST_WB,
    ST_HALTED,
    ST_ERROR
  } state_t;

  // The retired-instruction counter sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/matrix_instr_decode.sv
// Combinational opcode decoder: selects the functional unit (one-hot) and
// flags NOP, HALT, subtract and illegal opcodes.
module matrix_instr_decode
  import matrix_cpu_pkg::*;
#(
  parameter int NUM_UNITS = 4
) (
  input  logic [OP_W-1:0]      opcode,
  output logic [NUM_UNITS-1:0] unit_sel,
  output logic                 add_or_sub,
  output logic                 is_nop,
  output logic                 is_halt,
  output logic                 illegal
);

  always_comb begin
    unit_sel   = '0;
    add_or_sub = 1'b0;
    is_nop     = 1'b0;
    is_halt    = 1'b0;
    illegal    = 1'b0;
    case (opcode)
      OP_NOP:   is_nop = 1'b1;
      OP_ADD:   unit_sel[UNIT_ADD_SUB] = 1'b1;
      OP_SUB: begin
        unit_sel[UNIT_ADD_SUB] = 1'b1;
        add_or_sub             = 1'b1;
      end
      OP_SCALE: unit_sel[UNIT_SCALE] = 1'b1;
      OP_MULT:  unit_sel[UNIT_MULT]  = 1'b1;
      OP_TRANS: unit_sel[UNIT_TRANS] = 1'b1;
      OP_HALT:  is_halt = 1'b1;
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/matrix_seq_ctrl.sv
// Multi-cycle sequencer for the matrix CPU: fetch, decode, operand read,
// unit start/done handshake and write-back, stopping on HALT or an error.
module matrix_seq_ctrl
  import matrix_cpu_pkg::*;
#(
  parameter int ADDR_W    = 4,
  parameter int INSTR_W   = 27,
  parameter int REG_W     = 7,
  parameter int NUM_UNITS = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [ADDR_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0]   imem_data,
  output logic                 dmem_rd_en,
  output logic                 dmem_wr_en,
  output logic [REG_W-1:0]     dest,
  output logic [REG_W-1:0]     src1,
  output logic [REG_W-1:0]     src2,
  output logic [7:0]           scalar,
  output logic                 add_or_sub,
  output logic [NUM_UNITS-1:0] unit_start,
  input  logic [NUM_UNITS-1:0] unit_done,
  output logic                 busy,
  output logic                 halted,
  output logic [1:0]           err_code,
  output logic [15:0]          retired_cnt
);

  localparam int                 WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0]  PC_LAST   = '1;
  localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t               state;
  logic [ADDR_W-1:0]    pc;
  logic [WAIT_W-1:0]    wait_cnt;
  logic [NUM_UNITS-1:0] unit_sel_q;

  logic [NUM_UNITS-1:0] dec_unit_sel;
  logic                 dec_sub;
  logic                 dec_nop;
  logic                 dec_halt;
  logic                 dec_illegal;

  matrix_instr_decode #(
    .NUM_UNITS(NUM_UNITS)
  ) u_decode (
    .opcode    (imem_data[OP_LSB +: OP_W]),
    .unit_sel  (dec_unit_sel),
    .add_or_sub(dec_sub),
    .is_nop    (dec_nop),
    .is_halt   (dec_halt),
    .illegal   (dec_illegal)
  );

  assign imem_addr = pc;

  // Strobes default low every cycle so each is a single-cycle pulse set on the
  // transition into the state that owns it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      pc          <= '0;
      wait_cnt    <= '0;
      unit_sel_q  <= '0;
      dmem_rd_en  <= 1'b0;
      dmem_wr_en  <= 1'b0;
      dest        <= '0;
      src1        <= '0;
      src2        <= '0;
      scalar      <= '0;
      add_or_sub  <= 1'b0;
      unit_start  <= '0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      err_code    <= ERR_NONE;
      retired_cnt <= '0;
    end else begin
      dmem_rd_en <= 1'b0;
      dmem_wr_en <= 1'b0;
      unit_start <= '0;
      case (state)
        ST_IDLE, ST_HALTED, ST_ERROR: begin
          if (start) begin
            state       <= ST_FETCH;
            pc          <= '0;
            err_code    <= ERR_NONE;
            retired_cnt <= '0;
            busy        <= 1'b1;
            halted      <= 1'b0;
          end
        end
        ST_FETCH: state <= ST_DECODE;
        ST_DECODE: begin
          dest       <= imem_data[DEST_LSB +: REG_W];
          src1       <= imem_data[SRC1_LSB +: REG_W];
          src2       <= imem_data[SRC2_LSB +: REG_W];
          scalar     <= imem_data[SCALAR_LSB +: 8];
          add_or_sub <= dec_sub;
          unit_sel_q <= dec_unit_sel;
          if (dec_illegal) begin
            state    <= ST_ERROR;
            err_code <= ERR_ILLEGAL;
            busy     <= 1'b0;
          end else if (dec_halt) begin
            state  <= ST_HALTED;
            halted <= 1'b1;
            busy   <= 1'b0;
          end else if (dec_nop) begin
            retired_cnt <= sat_inc16(retired_cnt);
            if (pc == PC_LAST) begin
              state    <= ST_ERROR;
              err_code <= ERR_PC_OVF;
              busy     <= 1'b0;
            end else begin
              pc    <= pc + 1'b1;
              state <= ST_FETCH;
            end
          end else begin
            state      <= ST_READ;
            dmem_rd_en <= 1'b1;
          end
        end
        ST_READ: begin
          state      <= ST_EXEC;
          unit_start <= unit_sel_q;
          wait_cnt   <= '0;
        end
        // A done seen in the start cycle belongs to a previous operation and is ignored.
        ST_EXEC: begin
          if (wait_cnt != '0 && (unit_done & unit_sel_q) != '0) begin
            state      <= ST_WB;
            dmem_wr_en <= 1'b1;
          end else if (wait_cnt == WAIT_LAST) begin
            state    <= ST_ERROR;
            err_code <= ERR_TIMEOUT;
            busy     <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_WB: begin
          retired_cnt <= sat_inc16(retired_cnt);
          if (pc == PC_LAST) begin
            state    <= ST_ERROR;
            err_code <= ERR_PC_OVF;
            busy     <= 1'b0;
          end else begin
            pc    <= pc + 1'b1;
            state <= ST_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_seq_ctrl.sv
// Self-checking bench for matrix_seq_ctrl: instruction ROM and unit-done models,
// a scoreboard of expected operand/write-back events, and directed program runs.
module tb_matrix_seq_ctrl;
  import matrix_cpu_pkg::*;

  localparam int ADDR_W    = 4;
  localparam int INSTR_W   = 27;
  localparam int REG_W     = 7;
  localparam int NUM_UNITS = 4;
  localparam int TIMEOUT   = 64;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic [ADDR_W-1:0]    imem_addr;
  logic [INSTR_W-1:0]   imem_data;
  logic                 dmem_rd_en;
  logic                 dmem_wr_en;
  logic [REG_W-1:0]     dest;
  logic [REG_W-1:0]     src1;
  logic [REG_W-1:0]     src2;
  logic [7:0]           scalar;
  logic                 add_or_sub;
  logic [NUM_UNITS-1:0] unit_start;
  logic [NUM_UNITS-1:0] unit_done;
  logic [NUM_UNITS-1:0] auto_done   = '0;
  logic [NUM_UNITS-1:0] manual_done = '0;
  logic                 busy;
  logic                 halted;
  logic [1:0]           err_code;
  logic [15:0]          retired_cnt;

  typedef struct packed {
    logic [6:0] dest;
    logic [6:0] src1;
    logic [6:0] src2;
    logic [7:0] scalar;
    logic       sub;
    logic [3:0] unit;
  } exp_op_t;

  exp_op_t              sb[$];
  exp_op_t              mon_e;
  int                   us_q[$];
  int                   wr_q[$];
  logic [INSTR_W-1:0]   imem [2**ADDR_W];
  int                   cyc        = 0;
  int                   n_checks   = 0;
  int                   n_fail     = 0;
  int                   done_delay = 1;
  int                   pend_cnt   = 0;
  logic [NUM_UNITS-1:0] pend_sel   = '0;

  matrix_seq_ctrl #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .REG_W(REG_W),
    .NUM_UNITS(NUM_UNITS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .dmem_rd_en(dmem_rd_en), .dmem_wr_en(dmem_wr_en),
    .dest(dest), .src1(src1), .src2(src2), .scalar(scalar),
    .add_or_sub(add_or_sub), .unit_start(unit_start), .unit_done(unit_done),
    .busy(busy), .halted(halted), .err_code(err_code), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) imem_data <= imem[imem_addr];
  assign unit_done = auto_done | manual_done;

  // Unit model: pulse done for the started unit done_delay cycles after its start; 0 = never.
  always @(posedge clk) begin
    auto_done <= '0;
    if (reset) begin
      pend_cnt <= 0;
    end else if (unit_start != '0 && done_delay > 0) begin
      if (done_delay == 1) auto_done <= unit_start;
      else begin
        pend_cnt <= done_delay - 1;
        pend_sel <= unit_start;
      end
    end else if (pend_cnt > 0) begin
      if (pend_cnt == 1) auto_done <= pend_sel;
      pend_cnt <= pend_cnt - 1;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      check_output("strobe_excl",
                   32'($countones({dmem_rd_en, dmem_wr_en, |unit_start}) <= 1), 32'd1);
      if (unit_start != '0) begin
        us_q.push_back(cyc);
        if (sb.size() == 0) check_output("unit_start_unexpected", 32'(unit_start), 32'd0);
        else check_output("unit_start_sel", 32'(unit_start), 32'(sb[0].unit));
      end
      if (dmem_rd_en && sb.size() > 0) begin
        check_output("rd_src1", 32'(src1), 32'(sb[0].src1));
        check_output("rd_src2", 32'(src2), 32'(sb[0].src2));
      end
      if (dmem_wr_en) begin
        wr_q.push_back(cyc);
        if (sb.size() == 0) check_output("wr_unexpected", 32'(dmem_wr_en), 32'd0);
        else begin
          mon_e = sb.pop_front();
          check_output("wr_dest",   32'(dest),       32'(mon_e.dest));
          check_output("wr_src1",   32'(src1),       32'(mon_e.src1));
          check_output("wr_src2",   32'(src2),       32'(mon_e.src2));
          check_output("wr_scalar", 32'(scalar),     32'(mon_e.scalar));
          check_output("wr_sub",    32'(add_or_sub), 32'(mon_e.sub));
        end
      end
    end
  end

  function automatic logic [INSTR_W-1:0] mk_instr(input logic [4:0] op, input logic [6:0] d,
                                                  input logic [6:0] s1, input logic [6:0] s2);
    return {op, d, s1, s2, 1'b0};
  endfunction

  task automatic fill_prog(input logic [INSTR_W-1:0] w);
    for (int i = 0; i < 2**ADDR_W; i++) imem[i] = w;
    us_q.delete();
    wr_q.delete();
  endtask

  task automatic put(input int addr, input logic [4:0] op, input logic [6:0] d,
                     input logic [6:0] s1, input logic [6:0] s2,
                     input logic [3:0] unit, input logic sub);
    imem[addr] = mk_instr(op, d, s1, s2);
    if (unit != '0)
      sb.push_back('{dest: d, src1: s1, src2: s2, scalar: {s2, 1'b0}, sub: sub, unit: unit});
  endtask

  // Drives a one-cycle start; t0 is the cycle in which start is sampled.
  task automatic apply_stimulus(output int t0);
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag, output int t_end);
    int n = 0;
    while (busy === 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    t_end = cyc;
    if (busy !== 1'b0) check_output({tag, "_idle_timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_unit_start(input int budget, output int t);
    int n = 0;
    while (unit_start === '0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    t = cyc;
    if (unit_start === '0) check_output("unit_start_wait_timeout", 32'(unit_start != '0), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_imem_addr"},  32'(imem_addr),   32'd0);
    check_output({tag, "_rd_en"},      32'(dmem_rd_en),  32'd0);
    check_output({tag, "_wr_en"},      32'(dmem_wr_en),  32'd0);
    check_output({tag, "_dest"},       32'(dest),        32'd0);
    check_output({tag, "_src1"},       32'(src1),        32'd0);
    check_output({tag, "_src2"},       32'(src2),        32'd0);
    check_output({tag, "_scalar"},     32'(scalar),      32'd0);
    check_output({tag, "_add_or_sub"}, 32'(add_or_sub),  32'd0);
    check_output({tag, "_unit_start"}, 32'(unit_start),  32'd0);
    check_output({tag, "_busy"},       32'(busy),        32'd0);
    check_output({tag, "_halted"},     32'(halted),      32'd0);
    check_output({tag, "_err_code"},   32'(err_code),    32'd0);
    check_output({tag, "_retired"},    32'(retired_cnt), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the end of the test");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int t0, t1, tc, n;
    reset = 1'b1;
    start = 1'b0;
    fill_prog(mk_instr(OP_HALT, 0, 0, 0));
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    $display("[TB] ADD then HALT, done one cycle after start");
    done_delay = 1;
    fill_prog(mk_instr(OP_HALT, 0, 0, 0));
    put(0, OP_ADD, 7'd1, 7'd2, 7'd3, 4'b0001, 1'b0);
    apply_stimulus(t0);
    check_output("t1_busy_fetch", 32'(busy), 32'd1);
    wait_idle(100, "t1", t1);
    check_output("t1_us_cycle", (us_q.size() > 0) ? 32'(us_q[0] - t0) : 32'hFFFF_FFFF, 32'd4);
    check_output("t1_wr_cycle", (wr_q.size() > 0) ? 32'(wr_q[0] - t0) : 32'hFFFF_FFFF, 32'd6);
    check_output("t1_halted",  32'(halted),      32'd1);
    check_output("t1_retired", 32'(retired_cnt), 32'd1);
    check_output("t1_err",     32'(err_code),    32'd0);
    check_output("t1_sb_left", 32'(sb.size()),   32'd0);

    $display("[TB] SUB and SCALE field routing");
    fill_prog(mk_instr(OP_HALT, 0, 0, 0));
    put(0, OP_SUB,   7'd9, 7'd3, 7'd4,  4'b0001, 1'b1);
    put(1, OP_SCALE, 7'd5, 7'd6, 7'h2A, 4'b0010, 1'b0);
    apply_stimulus(t0);
    wait_idle(100, "t2", t1);
    check_output("t2_wr_count", 32'(wr_q.size()),  32'd2);
    check_output("t2_retired",  32'(retired_cnt),  32'd2);
    check_output("t2_halted",   32'(halted),       32'd1);
    check_output("t2_sb_left",  32'(sb.size()),    32'd0);

    $display("[TB] MULT with 20-cycle latency and stray done bits");
    done_delay = 20;
    fill_prog(mk_instr(OP_HALT, 0, 0, 0));
    put(0, OP_MULT, 7'd10, 7'd11, 7'd12, 4'b0100, 1'b0);
    apply_stimulus(t0);
    wait_unit_start(20, tc);
    manual_done = 4'b0100;
    @(negedge clk);
    manual_done = 4'b0001;
    @(negedge clk);
    manual_done = '0;
    repeat (3) @(negedge clk);
    manual_done = 4'b1011;
    @(negedge clk);
    manual_done = '0;
    wait_idle(100, "t3", t1);
    check_output("t3_exec_len", (wr_q.size() > 0) ? 32'(wr_q[0] - tc) : 32'hFFFF_FFFF, 32'd21);
    check_output("t3_retired",  32'(retired_cnt), 32'd1);
    check_output("t3_halted",   32'(halted),      32'd1);

    $display("[TB] illegal opcode at address 2, then restart");
    done_delay = 1;
    fill_prog(mk_instr(OP_HALT, 0, 0, 0));
    put(0, OP_NOP, 0, 0, 0, 4'b0000, 1'b0);
    put(1, OP_ADD, 7'd1, 7'd1, 7'd1, 4'b0001, 1'b0);
    put(2, 5'h07, 0, 0, 0, 4'b0000, 1'b0);
    apply_stimulus(t0);
    wait_idle(100, "t4", t1);
    check_output("t4_err",       32'(err_code),    32'd1);
    check_output("t4_busy",      32'(busy),        32'd0);
    check_output("t4_halted",    32'(halted),      32'd0);
    check_output("t4_retired",   32'(retired_cnt), 32'd2);
    check_output("t4_imem_addr", 32'(imem_addr),   32'd2);
    fill_prog(mk_instr(OP_HALT, 0, 0, 0));
    apply_stimulus(t0);
    check_output("t4_restart_err",  32'(err_code),    32'd0);
    check_output("t4_restart_pc",   32'(imem_addr),   32'd0);
    check_output("t4_restart_ret",  32'(retired_cnt), 32'd0);
    check_output("t4_restart_busy", 32'(busy),        32'd1);
    wait_idle(100, "t4r", t1);
    check_output("t4_restart_halted", 32'(halted), 32'd1);

    $display("[TB] TRANS without done -> timeout");
    done_delay = 0;
    fill_prog(mk_instr(OP_HALT, 0, 0, 0));
    put(0, OP_TRANS, 7'd2, 7'd3, 7'd4, 4'b1000, 1'b0);
    apply_stimulus(t0);
    wait_unit_start(20, tc);
    n = 0;
    while (err_code !== 2'd2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_output("t5_timeout_cycles", 32'(n),           32'(TIMEOUT));
    check_output("t5_err",            32'(err_code),    32'd2);
    check_output("t5_busy",           32'(busy),        32'd0);
    check_output("t5_retired",        32'(retired_cnt), 32'd0);
    check_output("t5_sb_left",        32'(sb.size()),   32'd1);
    sb.delete();

    $display("[TB] 16 NOPs without HALT -> PC overflow");
    fill_prog(mk_instr(OP_NOP, 0, 0, 0));
    apply_stimulus(t0);
    wait_idle(100, "t5b", t1);
    check_output("t5b_cycles",    32'(t1 - t0),     32'd33);
    check_output("t5b_err",       32'(err_code),    32'd3);
    check_output("t5b_retired",   32'(retired_cnt), 32'd16);
    check_output("t5b_imem_addr", 32'(imem_addr),   32'd15);
    check_output("t5b_halted",    32'(halted),      32'd0);

    $display("[TB] start while busy, then reset in the unit_start cycle");
    fill_prog(mk_instr(OP_HALT, 0, 0, 0));
    put(0, OP_NOP, 0, 0, 0, 4'b0000, 1'b0);
    put(1, OP_NOP, 0, 0, 0, 4'b0000, 1'b0);
    put(2, OP_ADD, 7'd7, 7'd8, 7'd9, 4'b0001, 1'b0);
    apply_stimulus(t0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_unit_start(20, tc);
    check_output("t6_us_cycle",  32'(tc - t0),     32'd8);
    check_output("t6_retired",   32'(retired_cnt), 32'd2);
    check_output("t6_imem_addr", 32'(imem_addr),   32'd2);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("t6_reset");
    reset = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
